// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
//
// Shares one BITWIDTH-wide adder-subtractor unit (AU) between two requesters
// (for example the SDRAM burst address incrementer and the refresh/row
// counter). Requests are granted round-robin. The granted operands and op are
// registered onto the AU inputs, the AU start strobe is pulsed, and the block
// waits the fixed AU latency. It then captures the AU result and overflow flag
// and returns them to the granted requester with a one-cycle done pulse.
//
// Parameters:
//   BITWIDTH    operand/result width
//   AU_LAT      cycles from the end of the au_start cycle to a valid
//               au_result/au_ovf (1..15)
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   req0_i       requester 0 request, held until done0_o is seen
//   a0_i, b0_i   requester 0 operands
//   sub0_i       requester 0 op (1 = A-B, 0 = A+B)
//   req1_i, a1_i, b1_i, sub1_i   same signals for requester 1
//   done0_o      one-cycle pulse, result_o/ovf_o valid for requester 0
//   done1_o      one-cycle pulse, result_o/ovf_o valid for requester 1
//   result_o     captured AU result
//   ovf_o        captured AU overflow
//   busy_o       high in every state except IDLE
//   au_a_o       registered operand A to the AU
//   au_b_o       registered operand B to the AU
//   au_sub_o     registered op to the AU
//   au_start_o   one-cycle AU launch strobe
//   au_result_i  AU result
//   au_ovf_i     AU overflow (carry/borrow out), passed through unmodified
// ---------------------------------------------------------------------------
module addsub_arbiter #(
  parameter int BITWIDTH = 8,
  parameter int AU_LAT   = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req0_i,
  input  logic [BITWIDTH-1:0] a0_i,
  input  logic [BITWIDTH-1:0] b0_i,
  input  logic                sub0_i,
  input  logic                req1_i,
  input  logic [BITWIDTH-1:0] a1_i,
  input  logic [BITWIDTH-1:0] b1_i,
  input  logic                sub1_i,
  output logic                done0_o,
  output logic                done1_o,
  output logic [BITWIDTH-1:0] result_o,
  output logic                ovf_o,
  output logic                busy_o,
  output logic [BITWIDTH-1:0] au_a_o,
  output logic [BITWIDTH-1:0] au_b_o,
  output logic                au_sub_o,
  output logic                au_start_o,
  input  logic [BITWIDTH-1:0] au_result_i,
  input  logic                au_ovf_i
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Latency counter start value; 4 bits covers the full 1..15 range.
  localparam logic [3:0] LAT_LOAD = 4'(AU_LAT);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                lastGrant_q, lastGrant_d;
  logic [BITWIDTH-1:0] auA_q, auA_d;
  logic [BITWIDTH-1:0] auB_q, auB_d;
  logic                auSub_q, auSub_d;
  logic [BITWIDTH-1:0] result_q, result_d;
  logic                ovf_q, ovf_d;

  // Round-robin pick. Requester 1 wins when it is the only one asking, or
  // when both ask and requester 0 had the last grant; otherwise requester 0.
  logic anyReq;
  logic pick1;

  always_comb begin
    anyReq = req0_i | req1_i;
    pick1  = req1_i & (~req0_i | ~lastGrant_q);
  end

  // Next-state logic. Operands are latched only on the grant edge so later
  // changes on the requester inputs cannot disturb an operation in flight.
  // The AU result is captured on the last WAIT edge, when the counter has
  // run down to 1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    lastGrant_d = lastGrant_q;
    auA_d       = auA_q;
    auB_d       = auB_q;
    auSub_d     = auSub_q;
    result_d    = result_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          gnt_d       = pick1;
          lastGrant_d = pick1;
          auA_d       = pick1 ? a1_i   : a0_i;
          auB_d       = pick1 ? b1_i   : b0_i;
          auSub_d     = pick1 ? sub1_i : sub0_i;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d = au_result_i;
          ovf_d    = au_ovf_i;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. On reset, last grant points at requester 1
  // so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      gnt_q       <= 1'b0;
      lastGrant_q <= 1'b1;
      auA_q       <= '0;
      auB_q       <= '0;
      auSub_q     <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      lastGrant_q <= lastGrant_d;
      auA_q       <= auA_d;
      auB_q       <= auB_d;
      auSub_q     <= auSub_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  // Outputs are either registers or decodes of the state register, so none
  // of them has a combinational path from an input.
  always_comb begin
    busy_o     = (state_q != ST_IDLE);
    au_start_o = (state_q == ST_ISSUE);
    done0_o    = (state_q == ST_DONE) & ~gnt_q;
    done1_o    = (state_q == ST_DONE) &  gnt_q;
    au_a_o     = auA_q;
    au_b_o     = auB_q;
    au_sub_o   = auSub_q;
    result_o   = result_q;
    ovf_o      = ovf_q;
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_arbiter
//
// Directed self-checking bench for addsub_arbiter. A small latency-accurate
// adder-subtractor model sits on the AU port. It drives a poison value
// whenever no result is due, so a capture on the wrong edge shows up.
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;

  localparam int W   = 8;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, sub0, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         done0, done1, ovf, busy, auSub, auStart, auOvf;
  logic [W-1:0] result, auA, auB, auResult;

  int testsRun    = 0;
  int testsFailed = 0;

  addsub_arbiter #(.BITWIDTH(W), .AU_LAT(LAT)) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_i(req0), .a0_i(a0), .b0_i(b0), .sub0_i(sub0),
    .req1_i(req1), .a1_i(a1), .b1_i(b1), .sub1_i(sub1),
    .done0_o(done0), .done1_o(done1), .result_o(result), .ovf_o(ovf),
    .busy_o(busy), .au_a_o(auA), .au_b_o(auB), .au_sub_o(auSub),
    .au_start_o(auStart), .au_result_i(auResult), .au_ovf_i(auOvf)
  );

  always #5 clk = ~clk;

  // AU model: launches on au_start and delivers {ovf,result} LAT-1 edges
  // later, so the value is present just before the LAT-th edge after the
  // au_start cycle ends. Otherwise it drives the poison value {1,A5}.
  logic [W:0] pipe [LAT];

  always @(posedge clk) begin
    if (auStart)
      pipe[0] <= auSub ? ({1'b0, auA} - {1'b0, auB}) : ({1'b0, auA} + {1'b0, auB});
    else
      pipe[0] <= {1'b1, 8'hA5};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign {auOvf, auResult} = pipe[LAT-1];

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, optionally changes operand A one cycle after the
  // grant edge, and waits (bounded) for a done pulse. It reports the latency
  // in negedges after the grant edge and which done fired (2 = both,
  // -1 = none), then drops the request.
  task automatic applyStimulus(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input logic chg, input logic [W-1:0] newA,
                               output int lat, output int whoDone);
    @(negedge clk);
    if (who == 0) begin a0 = a; b0 = b; sub0 = s; req0 = 1'b1; end
    else          begin a1 = a; b1 = b; sub1 = s; req1 = 1'b1; end
    lat = 0;
    whoDone = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checkOutput("au_start after grant", auStart, 1'b1);
        checkOutput("au_a at grant", auA, a);
        if (chg) begin
          if (who == 0) a0 = newA; else a1 = newA;
        end
      end
      if (done0 || done1) begin
        lat = i;
        whoDone = (done0 && done1) ? 2 : (done0 ? 0 : 1);
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  int lat, whoDone;
  int order [4];
  logic sawDone;

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("reset busy", busy, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset au_a", auA, 0);
    checkOutput("reset au_b", auB, 0);
    checkOutput("reset au_sub", auSub, 0);
    checkOutput("reset au_start", auStart, 0);
    checkOutput("reset done", {done0, done1}, 0);
    reset = 1'b0;

    // Single add: 12+34 = 46, no carry, done 4 cycles after the sample edge
    applyStimulus(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, lat, whoDone);
    checkOutput("add latency", lat, 4);
    checkOutput("add who", whoDone, 0);
    checkOutput("add result", result, 8'h46);
    checkOutput("add ovf", ovf, 0);
    @(negedge clk);
    checkOutput("add done width", {done0, done1}, 0);
    checkOutput("result holds", result, 8'h46);

    // Subtract with borrow: 05-07 = FE, borrow out
    applyStimulus(0, 8'h05, 8'h07, 1'b1, 1'b0, 8'h00, lat, whoDone);
    checkOutput("sub who", whoDone, 0);
    checkOutput("sub au_sub", auSub, 1);
    checkOutput("sub result", result, 8'hFE);
    checkOutput("sub ovf", ovf, 1);
    @(negedge clk);

    // Operand change after grant: au_a stays 01, 01+02 = 03
    applyStimulus(0, 8'h01, 8'h02, 1'b0, 1'b1, 8'h80, lat, whoDone);
    checkOutput("chg au_a held", auA, 8'h01);
    checkOutput("chg result", result, 8'h03);
    checkOutput("chg ovf", ovf, 0);
    @(negedge clk);

    // Overflow: FF+01 = 00 with carry, reported on done1
    applyStimulus(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, lat, whoDone);
    checkOutput("ovf who", whoDone, 1);
    checkOutput("ovf latency", lat, 4);
    checkOutput("ovf result", result, 8'h00);
    checkOutput("ovf flag", ovf, 1);
    @(negedge clk);

    // Contention: last grant was 1, so grants run 0,1,0,1.
    // Requester 0: 10+20 = 30; requester 1: 50-10 = 40.
    @(negedge clk);
    a0 = 8'h10; b0 = 8'h20; sub0 = 0;
    a1 = 8'h50; b1 = 8'h10; sub1 = 1;
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      order[k] = -1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done0 || done1) begin
          order[k] = (done0 && done1) ? 2 : (done0 ? 0 : 1);
          break;
        end
      end
      checkOutput($sformatf("contention grant %0d", k), order[k], k % 2);
      checkOutput($sformatf("contention result %0d", k), result, (k % 2) ? 8'h40 : 8'h30);
      if (k == 3) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      checkOutput($sformatf("contention done width %0d", k), {done0, done1}, 0);
    end

    // Reset mid-WAIT, two cycles after au_start
    @(negedge clk);
    a0 = 8'h10; b0 = 8'h01; sub0 = 0; req0 = 1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("midrst au_start", auStart, 1);
      if (i == 3) checkOutput("midrst busy before", busy, 1);
    end
    reset = 1'b1;
    #1;
    checkOutput("midrst result cleared", result, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst au_a", auA, 0);
    checkOutput("midrst au_b", auB, 0);
    checkOutput("midrst done", {done0, done1}, 0);
    req0 = 0;
    sawDone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) sawDone = 1;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || done1) sawDone = 1;
    end
    checkOutput("midrst no done", sawDone, 0);
    checkOutput("midrst busy after", busy, 0);

    // After reset, requester 0 wins the first tie
    a0 = 8'h03; b0 = 8'h04; sub0 = 0;
    a1 = 8'h09; b1 = 8'h01; sub1 = 0;
    req0 = 1; req1 = 1;
    whoDone = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        whoDone = (done0 && done1) ? 2 : (done0 ? 0 : 1);
        break;
      end
    end
    req0 = 0; req1 = 0;
    checkOutput("post-reset first grant", whoDone, 0);
    checkOutput("post-reset result", result, 8'h07);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
